// File: rtl/fifo_pkg.sv
// Shared types and pointer-coding helpers for the async FIFO pointer logic.
// Latency: n/a (package only, no state).
// Backpressure: n/a.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;

  // Helpers work on a fixed maximum width; callers widen their pointer with a
  // size cast on the way in and narrow the result on the way out. Zero
  // extension is harmless for both directions of gray coding.
  localparam int GRAY_MAX_W = 32;

  typedef logic [GRAY_MAX_W-1:0] gvec_t;
  typedef logic [1:0]            occ_t;

  function automatic gvec_t bin2gray(input gvec_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic gvec_t gray2bin(input gvec_t g);
    gvec_t b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_obuf.sv
// 2-entry output buffer absorbing the 1-cycle memory read latency.
// Latency: a pushed word reaches the head (out_data/out_valid) the next cycle when empty.
// Backpressure: holds words while out_ready=0; caller guarantees occ+inflight never exceeds 2.
//
// Ports:
//   rclk, rrst        clock, synchronous active-high reset
//   push, push_data   word arriving from memory this cycle
//   out_data/out_valid/out_ready  head word stream
//   pop               head word accepted this cycle (out_valid & out_ready)
//   occ               number of buffered words (0..2)
module fifo_rd_obuf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  pop,
  output occ_t                  occ
);

  logic [DATA_WIDTH-1:0] d0;  // head
  logic [DATA_WIDTH-1:0] d1;  // second entry
  occ_t                  occ_q;

  assign out_valid = (occ_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_data  = d0;
  assign occ       = occ_q;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      occ_q <= 2'd0;
      d0    <= '0;
      d1    <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) d0 <= push_data;
          else               d1 <= push_data;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          d0    <= d1;
          occ_q <= occ_q - 2'd1;
        end
        2'b11: begin
          // Arrival lands behind whatever is left after the pop.
          if (occ_q == 2'd2) begin
            d0 <= d1;
            d1 <= push_data;
          end else begin
            d0 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: read pointer, empty flag, memory fetch, output stream.
// Latency: rempty falls at N, fetch at N, out_valid at N+2; 1 word/cycle sustained.
// Backpressure: out_ready=0 stops fetching once buffered+in-flight words reach 2; nothing lost.
//
// Ports:
//   rclk, rrst        clock, synchronous active-high reset
//   rq2_wptr          gray write pointer, already synchronized into rclk
//   rptr              registered gray read pointer toward the write domain
//   rempty            registered empty flag (also feeds the memory)
//   raddr, rclken     memory read address / read enable (combinational)
//   mem_rdata         memory data, valid the cycle after rclken
//   out_data/out_valid/out_ready  output word stream
//   rlevel            only with FIFO_RD_LEVEL_EN: words visible to the read side, not
//                     counting buffered words (registered, conservative)
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic [ADDR_WIDTH:0]   rq2_wptr,
  output logic [ADDR_WIDTH:0]   rptr,
  output logic                  rempty,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic                  rclken,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef FIFO_RD_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   rlevel
`endif
);

  localparam int PTR_W = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH:0] rbin;
  logic [ADDR_WIDTH:0] rbin_next;
  logic [ADDR_WIDTH:0] rgray_next;
  logic                inflight;
  logic                fetch;
  logic                pop;
  occ_t                occ;
  occ_t                pending;

  // Words already committed to the buffer: stored plus one in flight from memory.
  assign pending = occ + {1'b0, inflight};

  // A pop in the same cycle frees a slot, so fetching at pending=2 stays safe.
  assign fetch  = !rrst && !rempty && ((pending < 2'd2) || pop);
  assign rclken = fetch;
  assign raddr  = rbin[ADDR_WIDTH-1:0];

  always_comb begin
    rbin_next  = rbin + {{ADDR_WIDTH{1'b0}}, fetch};
    rgray_next = PTR_W'(bin2gray(GRAY_MAX_W'(rbin_next)));
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin     <= '0;
      rptr     <= '0;
      rempty   <= 1'b1;
      inflight <= 1'b0;
    end else begin
      rbin     <= rbin_next;
      rptr     <= rgray_next;
      rempty   <= (rgray_next == rq2_wptr);
      inflight <= fetch;
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  always_ff @(posedge rclk) begin
    if (rrst) rlevel <= '0;
    else      rlevel <= PTR_W'(gray2bin(GRAY_MAX_W'(rq2_wptr))) - rbin;
  end
`endif

  // The in-flight flag is cleared by reset, so a stale word returned by the
  // memory right after reset is never pushed.
  fifo_rd_obuf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_obuf (
    .rclk      (rclk),
    .rrst      (rrst),
    .push      (inflight),
    .push_data (mem_rdata),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .pop       (pop),
    .occ       (occ)
  );

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed and randomized checks of fifo_rd_ctrl against a memory model and word scoreboard.
// Latency: n/a (testbench).
// Backpressure: drives out_ready as fixed 0, fixed 1, or random per phase.
module tb_fifo_rd_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          rclk = 1'b0;
    logic          rrst;
    logic [AW:0]   rq2_wptr;
    logic [AW:0]   rptr;
    logic          rempty;
    logic [AW-1:0] raddr;
    logic          rclken;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
`ifdef FIFO_RD_LEVEL_EN
    logic [AW:0]   rlevel;
`endif

    fifo_rd_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .rq2_wptr  (rq2_wptr),
        .rptr      (rptr),
        .rempty    (rempty),
        .raddr     (raddr),
        .rclken    (rclken),
        .mem_rdata (mem_rdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef FIFO_RD_LEVEL_EN
        ,
        .rlevel    (rlevel)
`endif
    );

    always #5 rclk = ~rclk;

    logic [DW-1:0] mem [0:15];
    logic          inj;
    always @(posedge rclk) mem_rdata <= inj ? 8'hEE : (rclken ? mem[raddr] : 8'h00);

    int          nvec = 0;
    int          nmis = 0;
    logic [4:0]  wbin;
    logic [4:0]  wbin_prev;
    logic [4:0]  rd_cnt;
    logic [4:0]  lvl_exp;
    bit          lvl_ok;
    logic [7:0]  wval;
    logic [7:0]  q [$];
    int          nf, nv, fv, lv;

    function automatic logic [4:0] g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge rclk);
        rrst = 1'b1; out_ready = 1'b0; wbin = '0; rq2_wptr = '0;
        q.delete(); rd_cnt = '0; lvl_ok = 1'b0;
        @(negedge rclk);
        rrst = 1'b0;
    endtask

    task automatic run(input int ncyc, input int nwr, input int rmode, input bit rndw,
                       output int nfetch, output int npop, output int firstp, output int lastp);
        int         written;
        logic [4:0] diff;
        bit         do_w;
        written = 0; nfetch = 0; npop = 0; firstp = -1; lastp = -1;
        lvl_ok = 1'b0; wbin_prev = wbin;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge rclk);
`ifdef FIFO_RD_LEVEL_EN
            if (lvl_ok) chk("rlevel", rlevel, lvl_exp);
`endif
            diff = wbin - rd_cnt;
            do_w = (written < nwr) && (diff < 5'd16) && (!rndw || ($urandom_range(0, 1) == 1));
            if (do_w) begin
                mem[wbin[3:0]] = wval;
                q.push_back(wval);
                wval++; wbin++; written++;
            end
            rq2_wptr = g(wbin);
            case (rmode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            chk("rptr", rptr, g(rd_cnt));
            chk("rempty", rempty, (rd_cnt == wbin_prev));
            if (rclken) begin
                chk("fetch_when_empty", rempty, 1'b0);
                chk("raddr", raddr, rd_cnt[3:0]);
                nfetch++;
            end
            if (out_valid) begin
                chk("valid_without_word", (q.size() != 0), 1'b1);
                if (q.size() != 0) begin
                    chk("out_data", out_data, q[0]);
                    if (out_ready) begin
                        void'(q.pop_front());
                        if (firstp < 0) firstp = c;
                        lastp = c;
                        npop++;
                    end
                end
            end
            lvl_exp = wbin - rd_cnt;
            lvl_ok  = 1'b1;
            if (rclken) rd_cnt++;
            wbin_prev = wbin;
        end
    endtask

    initial begin
        rrst = 1'b1; out_ready = 1'b0; rq2_wptr = '0; inj = 1'b0;
        wbin = '0; rd_cnt = '0; wval = 8'h10; lvl_ok = 1'b0;

        for (int c = 0; c < 3; c++) begin
            @(negedge rclk); #1;
            chk("rst_rempty", rempty, 1'b1);
            chk("rst_rptr", rptr, 5'd0);
            chk("rst_rclken", rclken, 1'b0);
            chk("rst_out_valid", out_valid, 1'b0);
        end
        chk("rst_out_data", out_data, 8'h00);
        @(negedge rclk); rrst = 1'b0; #1;
        chk("idle_rclken", rclken, 1'b0);
        @(negedge rclk); #1;
        chk("idle_rempty", rempty, 1'b1);
        chk("idle_out_valid", out_valid, 1'b0);
`ifdef FIFO_RD_LEVEL_EN
        chk("idle_rlevel", rlevel, 5'd0);
`endif

        @(negedge rclk);
        mem[0] = 8'hA5; wbin = 5'd1; rq2_wptr = g(5'd1); out_ready = 1'b1; #1;
        chk("w1_no_fetch_yet", rclken, 1'b0);
        @(negedge rclk); #1;
        chk("w1_rempty_low", rempty, 1'b0);
        chk("w1_fetch", rclken, 1'b1);
        chk("w1_raddr", raddr, 4'd0);
        @(negedge rclk); #1;
        chk("w1_rempty_back", rempty, 1'b1);
        chk("w1_no_refetch", rclken, 1'b0);
        chk("w1_rptr", rptr, 5'b00001);
        chk("w1_not_valid_yet", out_valid, 1'b0);
        @(negedge rclk); #1;
        chk("w1_valid", out_valid, 1'b1);
        chk("w1_data", out_data, 8'hA5);
        @(negedge rclk); #1;
        chk("w1_drained", out_valid, 1'b0);

        reset_dut();
        run(40, 16, 1, 1'b0, nf, nv, fv, lv);
        chk("lap_fetches", nf, 16);
        chk("lap_words", nv, 16);
        chk("lap_gapless", lv - fv, 15);
        chk("lap_rempty", rempty, 1'b1);
        chk("lap_rptr", rptr, 5'b11000);
        chk("lap_raddr", raddr, 4'd0);
        chk("lap_queue_empty", q.size(), 0);

        run(8, 4, 0, 1'b0, nf, nv, fv, lv);
        chk("bp_fetches", nf, 2);
        chk("bp_valid", out_valid, 1'b1);
        chk("bp_head", out_data, 8'h20);
        run(8, 0, 1, 1'b0, nf, nv, fv, lv);
        chk("bp_words", nv, 4);
        chk("bp_gapless", lv - fv, 3);
        chk("bp_rest_fetches", nf, 2);
        chk("bp_queue_empty", q.size(), 0);

        run(6, 4, 0, 1'b0, nf, nv, fv, lv);
        chk("mr_fetches", nf, 2);
        chk("mr_head", out_data, 8'h24);
        @(negedge rclk); out_ready = 1'b1; #1;
        chk("mr_pop_fetch", rclken, 1'b1);
        @(negedge rclk); rrst = 1'b1; inj = 1'b1; rq2_wptr = '0; #1;
        chk("mr_rclken_in_rst", rclken, 1'b0);
        @(negedge rclk); rrst = 1'b0; inj = 1'b0; wbin = '0; q.delete(); rd_cnt = '0; #1;
        chk("mr_out_valid", out_valid, 1'b0);
        chk("mr_rptr", rptr, 5'd0);
        chk("mr_rempty", rempty, 1'b1);
        chk("mr_rclken", rclken, 1'b0);
        @(negedge rclk); #1;
        chk("mr_stale_dropped", out_valid, 1'b0);
        chk("mr_still_empty", rempty, 1'b1);

        run(400, 150, 2, 1'b1, nf, nv, fv, lv);
        run(40, 0, 1, 1'b0, nf, nv, fv, lv);
        chk("rnd_queue_empty", q.size(), 0);
        chk("rnd_rempty", rempty, 1'b1);
        chk("rnd_rptr", rptr, g(rd_cnt));
        chk("rnd_all_read", rd_cnt, wbin);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
